// File: rtl/alu_acc_pkg.sv
// Shared encodings for the accumulator sequencer: command opcodes, FSM states,
// status flag bit positions and the flag helper used for LOAD.
package alu_acc_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_CMP  = 3'd3,
    OP_ADDN = 3'd4,
    OP_CLR  = 3'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] FLAGS_RST = 4'b0100;

  // N and Z derived from a value; C and V cleared.
  function automatic logic [3:0] nz_flags(input logic [31:0] value);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = value[31];
    f[FLAG_Z] = (value == 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/alu_addsub32.sv
// 32-bit combinational add/subtract ALU; lives beside alu_acc_seq in the parent.
// Subtraction is a + ~b + 1, so carry = 1 means no borrow.
module alu_addsub32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_result,
  output logic        o_carry,
  output logic        o_zero,
  output logic        o_overflow
);

  logic [31:0] w_b_eff;
  logic [32:0] w_sum;

  assign w_b_eff    = i_sub ? ~i_b : i_b;
  assign w_sum      = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, i_sub};
  assign o_result   = w_sum[31:0];
  assign o_carry    = w_sum[32];
  assign o_zero     = (w_sum[31:0] == 32'd0);
  // Signed overflow: both addends share a sign that the result does not.
  assign o_overflow = (i_a[31] == w_b_eff[31]) && (w_sum[31] != i_a[31]);

endmodule

// File: rtl/alu_acc_seq.sv
// Command sequencer/accumulator around the external add/sub ALU: single
// LOAD/ADD/SUB/CMP/CLR commands plus ADDN (repeated add, one ALU pass per cycle).
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_operand,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_sub_add,
  input  logic [31:0]      alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic [31:0]      acc,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [31:0]      r_acc;
  logic [31:0]      r_b;
  logic [3:0]       r_flags;
  logic             r_sticky;
  logic             r_sub;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [3:0]       w_alu_flags;

  assign w_alu_flags = {alu_result[31], alu_zero, alu_carry, alu_overflow};

  assign cmd_ready   = (r_state == IDLE) && !rst;
  assign alu_a       = r_acc;
  assign alu_b       = r_b;
  assign alu_sub_add = r_sub;
  assign acc         = r_acc;
  assign flags       = r_flags;
  assign sticky_v    = r_sticky;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

  // Sequencer FSM; the ALU result is sampled in the same EXEC cycle it is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_rem    <= '0;
      r_acc    <= 32'd0;
      r_b      <= 32'd0;
      r_flags  <= FLAGS_RST;
      r_sticky <= 1'b0;
      r_sub    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_b     <= cmd_operand;
            r_rem   <= (cmd_op == OP_ADDN) ? cmd_cnt : CNT_W'(1);
            r_sub   <= (cmd_op == OP_SUB) || (cmd_op == OP_CMP);
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end else begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          case (r_op)
            OP_LOAD: begin
              r_acc   <= r_b;
              r_flags <= nz_flags(r_b);
            end
            OP_ADD, OP_SUB: begin
              r_acc    <= alu_result;
              r_flags  <= w_alu_flags;
              r_sticky <= r_sticky | alu_overflow;
            end
            OP_CMP: r_flags <= w_alu_flags;
            OP_ADDN: begin
              // A zero count still spends one EXEC cycle but touches nothing.
              if (r_rem != '0) begin
                r_acc    <= alu_result;
                r_flags  <= w_alu_flags;
                r_sticky <= r_sticky | alu_overflow;
              end else begin
                r_acc <= r_acc;
              end
            end
            OP_CLR: begin
              r_acc    <= 32'd0;
              r_flags  <= FLAGS_RST;
              r_sticky <= 1'b0;
            end
            default: r_err <= 1'b1;
          endcase
          if ((r_op == OP_ADDN) && (r_rem > CNT_W'(1))) begin
            r_rem <= r_rem - CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sub   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq with the add/sub ALU wired beside it.
module tb_alu_acc_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_operand;
  logic [CNT_W-1:0] cmd_cnt;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic             alu_sub_add, alu_carry, alu_zero, alu_overflow;
  logic [31:0]      acc;
  logic [3:0]       flags;
  logic             sticky_v, busy, done, err;

  always #5 clk = ~clk;

  alu_addsub32 u_alu (
    .i_a(alu_a), .i_b(alu_b), .i_sub(alu_sub_add),
    .o_result(alu_result), .o_carry(alu_carry), .o_zero(alu_zero), .o_overflow(alu_overflow)
  );

  alu_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_cnt(cmd_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub_add(alu_sub_add),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .acc(acc), .flags(flags), .sticky_v(sticky_v),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] acc;
    logic [3:0]  flags;
    logic        sticky;
    logic        err;
    logic        sub;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] m_acc = 32'd0;
  logic [3:0]  m_flags = 4'b0100;
  logic        m_sticky = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic on the architectural state.
  task automatic model_add(input logic [31:0] b);
    logic [32:0] s;
    logic        v;
    s = {1'b0, m_acc} + {1'b0, b};
    v = (m_acc[31] == b[31]) && (s[31] != m_acc[31]);
    m_flags  = {s[31], s[31:0] == 32'd0, s[32], v};
    m_sticky = m_sticky | v;
    m_acc    = s[31:0];
  endtask

  task automatic model_sub(input logic [31:0] b, input bit write);
    logic [31:0] r;
    logic        v;
    r = m_acc - b;
    v = (m_acc[31] != b[31]) && (r[31] != m_acc[31]);
    m_flags = {r[31], r == 32'd0, m_acc >= b, v};
    if (write) begin
      m_sticky = m_sticky | v;
      m_acc    = r;
    end
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [31:0] b, input int n, output logic e);
    e = 1'b0;
    case (op)
      3'd0: begin m_acc = b; m_flags = {b[31], b == 32'd0, 2'b00}; end
      3'd1: model_add(b);
      3'd2: model_sub(b, 1'b1);
      3'd3: model_sub(b, 1'b0);
      3'd4: for (int i = 0; i < n; i++) model_add(b);
      3'd5: begin m_acc = 32'd0; m_flags = 4'b0100; m_sticky = 1'b0; end
      default: e = 1'b1;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] b, input int n);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = b;
    cmd_cnt     = CNT_W'(n);
    e.busy_n    = (op == 3'd4 && n > 0) ? n : 1;
    e.done_cyc  = cyc + 1 + e.busy_n;
    e.sub       = (op == 3'd2) || (op == 3'd3);
    model_apply(op, b, n, e.err);
    e.acc       = m_acc;
    e.flags     = m_flags;
    e.sticky    = m_sticky;
    @(posedge clk);
    sb.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  // Monitor: scores every done pulse against the oldest expected response.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      chk("alu_a_eq_acc", alu_a, acc);
      if (busy) begin
        busy_cnt++;
        if (sb.size() > 0) chk("alu_sub_add", {31'd0, alu_sub_add}, {31'd0, sb[0].sub});
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("acc", acc, e.acc);
          chk("flags", {28'd0, flags}, {28'd0, e.flags});
          chk("sticky_v", {31'd0, sticky_v}, {31'd0, e.sticky});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
          chk("ready_in_done", {31'd0, cmd_ready}, 32'd1);
        end
        busy_cnt = 0;
      end else if (err) begin
        chk("err_without_done", {31'd0, err}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 32'd0; cmd_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'h4);
    chk("rst_sticky", {31'd0, sticky_v}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_sub_add", {31'd0, alu_sub_add}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    issue(3'd0, 32'h0000_0005, 0);
    issue(3'd0, 32'd1, 0);
    issue(3'd1, 32'h7FFF_FFFF, 0);
    issue(3'd0, 32'd5, 0);
    issue(3'd2, 32'd5, 0);
    issue(3'd0, 32'd5, 0);
    issue(3'd2, 32'd6, 0);
    issue(3'd0, 32'd2, 0);
    issue(3'd4, 32'd3, 4);
    issue(3'd4, 32'd3, 0);
    issue(3'd0, 32'h10, 0);
    issue(3'd3, 32'h10, 0);
    issue(3'd7, 32'hDEAD_BEEF, 0);
    issue(3'd6, 32'd1, 3);

    // cmd_valid held across the busy cycles of an ADDN must not be taken.
    issue(3'd4, 32'd1, 4);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_operand = 32'h100; cmd_cnt = '0;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    issue(3'd1, 32'd0, 0);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 8));
        1: b = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
        default: b = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), b, $urandom_range(0, 5));
    end

    // Reset in the second EXEC cycle of ADDN aborts it with no done pulse.
    issue(3'd1, 32'h7FFF_FFFF, 0);
    issue(3'd4, 32'd3, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_mid_rst", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_acc = 32'd0; m_flags = 4'b0100; m_sticky = 1'b0;
    @(negedge clk);
    chk("abort_acc", acc, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'h4);
    chk("abort_sticky", {31'd0, sticky_v}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_no_done", {30'd0, done, busy}, 32'd0);
    issue(3'd1, 32'd9, 0);

    for (int w = 0; w < 50 && sb.size() > 0; w++) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Sequencer/accumulator stage wrapped around the 32-bit add/sub ALU.
- Accepts commands over a valid/ready handshake.
- Drives the ALU operands and the sub/add select from its accumulator and a latched operand.
- Captures the ALU result and flags back into the accumulator and status register.
- Supports single add/sub/compare plus a repeated-add command (multiply by repeated addition).
- Sits between the command source and the combinational ALU, at the parent level.

## Interface
Parameters:
- CNT_W, 8, width of the repeat count for ADDN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE with rst low.
- cmd_op  in  3  operation: 0 LOAD, 1 ADD, 2 SUB, 3 CMP, 4 ADDN, 5 CLR; 6, 7 illegal.
- cmd_operand  in  32  operand B.
- cmd_cnt  in  CNT_W  iteration count, used by ADDN only.
- alu_a  out  32  ALU operand A, always equal to acc.
- alu_b  out  32  ALU operand B, always equal to the latched operand.
- alu_sub_add  out  1  1 during EXEC of SUB or CMP, else 0.
- alu_result  in  32  ALU sum/difference.
- alu_carry, alu_zero, alu_overflow  in  1 each  ALU flags.
- acc  out  32  accumulator.
- flags  out  4  {N,Z,C,V}.
- sticky_v  out  1  set by any overflowing ADD/SUB/ADDN iteration.
- busy  out  1  high in EXEC.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  pulses together with done for an illegal op.

## Operation
- FSM states are IDLE and EXEC.
- **IDLE:**
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch op, operand and cnt; load the remaining-count register rem (cnt for ADDN, 1 otherwise); go to EXEC.
- **EXEC, one cycle per iteration.** The ALU is combinational, so its result is sampled in the same cycle.
  - ADD/SUB:
    - acc ← alu_result.
    - flags ← {alu_result[31], alu_zero, alu_carry, alu_overflow}.
    - sticky_v |= alu_overflow.
  - CMP: same flag update as SUB; acc unchanged; sticky_v unchanged.
  - ADDN:
    - Each iteration performs ADD and decrements rem.
    - Stay in EXEC while rem > 1.
    - Final flags come from the last iteration.
    - cnt = 0: one EXEC cycle with no acc, flag or sticky update.
  - LOAD: acc ← operand; N and Z from the operand; C = 0, V = 0.
  - CLR: acc ← 0; flags ← 0100; sticky_v ← 0.
  - Illegal op: no state change; err pulses.
  - Leaving EXEC: return to IDLE and register done = 1.
- C is the raw ALU carry. For SUB/CMP, C = 1 means no borrow.
- 32-bit arithmetic wraps modulo 2^32; no saturation.
- cmd_valid held during busy is ignored and not queued.

## Timing
- Command accepted at edge T → EXEC occupies cycle T+1.
- For ADDN with cnt = n ≥ 1, EXEC occupies T+1..T+n.
- acc and flags are visible the cycle after the last EXEC cycle; done and err are high in that same cycle, for one cycle.
- cmd_ready returns high in the done cycle, so back-to-back single commands run at 1 per 2 cycles.
- Reset values:
  - acc = 0, flags = 0100, sticky_v = 0.
  - busy = 0, done = 0, err = 0.
  - cmd_ready = 0 while rst is high, 1 the cycle after rst falls.
  - alu_b = 0, alu_sub_add = 0.
- Reset mid-command aborts it: no done pulse, and all registers take their reset values.

## Structure
- Package alu_acc_pkg holds:
  - op encodings: OP_LOAD, OP_ADD, OP_SUB, OP_CMP, OP_ADDN, OP_CLR;
  - state enum {IDLE, EXEC};
  - flag bit indices: N = 3, Z = 2, C = 1, V = 0.
- No sub-module. The 32-bit add/sub ALU is instantiated beside this block in the parent, wired alu_a/alu_b/alu_sub_add → ALU → alu_result/flags.
- The bench instantiates both blocks.

## Test plan
- rst, then LOAD 0x0000_0005 → acc = 5, flags = 0000, done in T+2.
- acc = 1, ADD 0x7FFF_FFFF → acc = 0x8000_0000, flags = 1001, sticky_v = 1.
- acc = 5: SUB 5 → acc = 0, flags = 0110. Then from acc = 5, SUB 6 → acc = 0xFFFF_FFFF, flags = 1000.
- acc = 2, ADDN operand 3, cnt 4:
  - busy for 4 cycles, acc = 14, done at T+5.
  - ADDN with cnt 0 → acc unchanged, done at T+2.
- acc = 0x10: CMP 0x10 → flags Z = 1, C = 1, acc unchanged. Then op 7 → done and err pulse, no change. cmd_valid held during busy → not accepted.
- rst asserted in the 2nd cycle of ADDN cnt 4 → acc = 0, flags = 0100, no done, cmd_ready = 1 after rst falls.
